// File: rtl/cam_fbuf_capture.sv
// Camera byte capture into a banked frame buffer, read back over Wishbone.
// Define CAM_FBUF_BYTE_SWAP_EN to pack the first byte of each word into bits [7:0].
module cam_fbuf_capture #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BANK_AW   = 9,
  parameter int unsigned ADDRWIDTH = 11
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_n_i,
  input  logic [ADDRWIDTH-1:0] WBs_ADR_i,
  input  logic                 WBs_BUF_CYC_i,
  input  logic                 WBs_CTL_CYC_i,
  input  logic                 WBs_STB_i,
  input  logic                 WBs_WE_i,
  input  logic [31:0]          WBs_DAT_i,
  output logic [31:0]          WBs_DAT_o,
  output logic                 WBs_ACK_o,
  input  logic                 PCLKI,
  input  logic                 VSYNCI,
  input  logic                 HREFI,
  input  logic [7:0]           CAM_DAT,
  output logic                 Bank_Rdy_o
);

  localparam int unsigned BANK_BW   = $clog2(NUM_BANKS);
  localparam int unsigned MEM_AW    = BANK_AW + BANK_BW;
  localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
  localparam int unsigned DEPTH     = 1 << BANK_AW;
  localparam int unsigned FILL_W    = BANK_AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARM     = 2'd1,
    S_CAPTURE = 2'd2,
    S_STALL   = 2'd3
  } state_e;

  state_e               state;
  state_e               state_nxt;

  logic [1:0]           rst_sync;
  logic                 rst_n;

  logic [1:0]           pclk_s;
  logic [1:0]           vs_s;
  logic [1:0]           href_s;
  logic [7:0]           dat_s0;
  logic [7:0]           dat_s1;
  logic                 pclk_d;
  logic                 vs_d;

  logic                 enable;
  logic                 overflow;
  logic [NUM_BANKS-1:0] full;
  logic [BANK_BW-1:0]   wr_bank;
  logic [BANK_AW-1:0]   wr_ptr;
  logic [1:0]           byte_cnt;
  logic [31:0]          word_acc;
  logic [FILL_W-1:0]    fill_cnt;

  logic [31:0]          mem [0:MEM_DEPTH-1];

  logic                 pclk_rise_c;
  logic                 vs_rise_c;
  logic                 vs_fall_c;
  logic                 byte_in_c;
  logic [BANK_BW-1:0]   bank_inc_c;
  logic [31:0]          word_next_c;
  logic                 mem_we_c;
  logic [31:0]          mem_wdata_c;
  logic                 byte_acc_c;
  logic                 flush_c;
  logic                 drop_c;
  logic                 close_c;
  logic [FILL_W-1:0]    close_cnt_c;
  logic [FILL_W-1:0]    partial_cnt_c;
  logic                 bus_req_c;
  logic                 ctl_wr_c;
  logic [NUM_BANKS-1:0] rel_c;
  logic [NUM_BANKS-1:0] set_c;
  logic [NUM_BANKS-1:0] full_nxt_c;
  logic [31:0]          status_c;
  logic [31:0]          rd_data_c;
  logic                 unused_c;

  // Reset asserts immediately, releases two clocks after WBs_RST_n_i rises
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // Camera inputs are asynchronous to WBs_CLK_i; PCLKI is treated as data
  always_ff @(posedge WBs_CLK_i or negedge rst_n) begin
    if (!rst_n) begin
      pclk_s <= 2'b00;
      vs_s   <= 2'b00;
      href_s <= 2'b00;
      dat_s0 <= 8'd0;
      dat_s1 <= 8'd0;
      pclk_d <= 1'b0;
      vs_d   <= 1'b0;
    end else begin
      pclk_s <= {pclk_s[0], PCLKI};
      vs_s   <= {vs_s[0], VSYNCI};
      href_s <= {href_s[0], HREFI};
      dat_s0 <= CAM_DAT;
      dat_s1 <= dat_s0;
      pclk_d <= pclk_s[1];
      vs_d   <= vs_s[1];
    end
  end

  assign pclk_rise_c = pclk_s[1] & ~pclk_d;
  assign vs_rise_c   = vs_s[1] & ~vs_d;
  assign vs_fall_c   = ~vs_s[1] & vs_d;
  assign byte_in_c   = pclk_rise_c & href_s[1] & vs_s[1];
  assign bank_inc_c  = wr_bank + BANK_BW'(1);

  // Merge the incoming byte into the word under assembly
  always_comb begin
    word_next_c = word_acc;
`ifdef CAM_FBUF_BYTE_SWAP_EN
    case (byte_cnt)
      2'd0:    word_next_c[7:0]   = dat_s1;
      2'd1:    word_next_c[15:8]  = dat_s1;
      2'd2:    word_next_c[23:16] = dat_s1;
      default: word_next_c[31:24] = dat_s1;
    endcase
`else
    case (byte_cnt)
      2'd0:    word_next_c[31:24] = dat_s1;
      2'd1:    word_next_c[23:16] = dat_s1;
      2'd2:    word_next_c[15:8]  = dat_s1;
      default: word_next_c[7:0]   = dat_s1;
    endcase
`endif
  end

  always_ff @(posedge WBs_CLK_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the per-cycle capture actions
  always_comb begin
    state_nxt     = state;
    mem_we_c      = 1'b0;
    mem_wdata_c   = word_next_c;
    byte_acc_c    = 1'b0;
    flush_c       = 1'b0;
    drop_c        = 1'b0;
    close_c       = 1'b0;
    close_cnt_c   = FILL_W'(DEPTH);
    partial_cnt_c = FILL_W'(wr_ptr) + FILL_W'(byte_cnt != 2'd0);
    if (!enable) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_ARM;
        end
        S_ARM: begin
          if (vs_rise_c) begin
            state_nxt = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (vs_fall_c) begin
            flush_c   = 1'b1;
            state_nxt = S_ARM;
            if (byte_cnt != 2'd0) begin
              mem_we_c    = 1'b1;
              mem_wdata_c = word_acc;
            end
            // An empty bank stays open for the next frame
            if (partial_cnt_c != '0) begin
              close_c     = 1'b1;
              close_cnt_c = partial_cnt_c;
              if (full[bank_inc_c]) begin
                state_nxt = S_STALL;
              end
            end
          end else if (byte_in_c) begin
            byte_acc_c = 1'b1;
            if (byte_cnt == 2'd3) begin
              mem_we_c = 1'b1;
              if (wr_ptr == BANK_AW'(DEPTH - 1)) begin
                close_c = 1'b1;
                if (full[bank_inc_c]) begin
                  state_nxt = S_STALL;
                end
              end
            end
          end
        end
        S_STALL: begin
          drop_c = byte_in_c;
          if (!full[wr_bank]) begin
            state_nxt = S_ARM;
          end
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Write pointer, bank selection and word assembly
  always_ff @(posedge WBs_CLK_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank  <= '0;
      wr_ptr   <= '0;
      byte_cnt <= 2'd0;
      word_acc <= 32'd0;
      fill_cnt <= '0;
    end else if (!enable) begin
      wr_ptr   <= '0;
      byte_cnt <= 2'd0;
      word_acc <= 32'd0;
    end else begin
      if (close_c) begin
        wr_bank  <= bank_inc_c;
        wr_ptr   <= '0;
        fill_cnt <= close_cnt_c;
      end else if (mem_we_c) begin
        wr_ptr <= wr_ptr + BANK_AW'(1);
      end
      if (byte_acc_c) begin
        if (byte_cnt == 2'd3) begin
          byte_cnt <= 2'd0;
          word_acc <= 32'd0;
        end else begin
          byte_cnt <= byte_cnt + 2'd1;
          word_acc <= word_next_c;
        end
      end else if (flush_c) begin
        byte_cnt <= 2'd0;
        word_acc <= 32'd0;
      end
    end
  end

  always_ff @(posedge WBs_CLK_i) begin
    if (mem_we_c) begin
      mem[{wr_bank, wr_ptr}] <= mem_wdata_c;
    end
  end

  assign bus_req_c  = (WBs_BUF_CYC_i | WBs_CTL_CYC_i) & WBs_STB_i & ~WBs_ACK_o;
  assign ctl_wr_c   = bus_req_c & WBs_CTL_CYC_i & WBs_WE_i & (WBs_ADR_i == ADDRWIDTH'(0));
  assign rel_c      = ctl_wr_c ? WBs_DAT_i[8 +: NUM_BANKS] : '0;
  assign set_c      = close_c ? (NUM_BANKS'(1) << wr_bank) : '0;
  // A bank closing in the same cycle as its release stays full
  assign full_nxt_c = (full & ~rel_c) | set_c;
  assign unused_c   = &{1'b0, WBs_DAT_i[31:8+NUM_BANKS], WBs_DAT_i[7:2]};

  always_ff @(posedge WBs_CLK_i or negedge rst_n) begin
    if (!rst_n) begin
      enable     <= 1'b0;
      overflow   <= 1'b0;
      full       <= '0;
      Bank_Rdy_o <= 1'b0;
    end else begin
      if (ctl_wr_c) begin
        enable <= WBs_DAT_i[0];
      end
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (ctl_wr_c && WBs_DAT_i[1]) begin
        overflow <= 1'b0;
      end
      full       <= full_nxt_c;
      Bank_Rdy_o <= |full_nxt_c;
    end
  end

  // Read data mux: control/status registers or the capture memory
  always_comb begin
    status_c       = 32'd0;
    status_c[15:8] = 8'(full);
    status_c[6:4]  = 3'(wr_bank);
    status_c[3:2]  = state;
    status_c[1]    = overflow;
    status_c[0]    = enable;
    if (WBs_CTL_CYC_i) begin
      if (WBs_ADR_i == ADDRWIDTH'(0)) begin
        rd_data_c = status_c;
      end else if (WBs_ADR_i == ADDRWIDTH'(1)) begin
        rd_data_c = 32'(fill_cnt);
      end else begin
        rd_data_c = 32'd0;
      end
    end else begin
      rd_data_c = mem[WBs_ADR_i[MEM_AW-1:0]];
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge rst_n) begin
    if (!rst_n) begin
      WBs_ACK_o <= 1'b0;
      WBs_DAT_o <= 32'd0;
    end else begin
      WBs_ACK_o <= bus_req_c;
      if (bus_req_c) begin
        WBs_DAT_o <= rd_data_c;
      end
    end
  end

endmodule

// File: tb/tb_cam_fbuf_capture.sv
// Scoreboard bench for cam_fbuf_capture: a 4-bank default instance and a 2x4-word instance.
module tb_cam_fbuf_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] adr = '0;
  logic        cyc_buf_a = 1'b0, cyc_ctl_a = 1'b0;
  logic        cyc_buf_b = 1'b0, cyc_ctl_b = 1'b0;
  logic        stb = 1'b0, we = 1'b0;
  logic [31:0] wdat = '0;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, rdy_a, rdy_b;
  logic        pclk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0]  cam = '0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          chk_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  cam_fbuf_capture u_a (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .WBs_ADR_i(adr),
    .WBs_BUF_CYC_i(cyc_buf_a), .WBs_CTL_CYC_i(cyc_ctl_a), .WBs_STB_i(stb),
    .WBs_WE_i(we), .WBs_DAT_i(wdat), .WBs_DAT_o(dat_a), .WBs_ACK_o(ack_a),
    .PCLKI(pclk), .VSYNCI(vsync), .HREFI(href), .CAM_DAT(cam), .Bank_Rdy_o(rdy_a)
  );

  cam_fbuf_capture #(.NUM_BANKS(2), .BANK_AW(2), .ADDRWIDTH(3)) u_b (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n), .WBs_ADR_i(adr[2:0]),
    .WBs_BUF_CYC_i(cyc_buf_b), .WBs_CTL_CYC_i(cyc_ctl_b), .WBs_STB_i(stb),
    .WBs_WE_i(we), .WBs_DAT_i(wdat), .WBs_DAT_o(dat_b), .WBs_ACK_o(ack_b),
    .PCLKI(pclk), .VSYNCI(vsync), .HREFI(href), .CAM_DAT(cam), .Bank_Rdy_o(rdy_b)
  );

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h required %08h", n, act, exp);
    end
  endtask

  // Pops one scoreboard entry per acknowledge and checks ACK is a one-cycle pulse
  task automatic monitor();
    logic [31:0] act;
    logic [31:0] e;
    bit          c;
    string       n;
    bit          pa = 1'b0;
    bit          pb = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_a || ack_b) begin
        act = ack_a ? dat_a : dat_b;
        checks++;
        if ((ack_a && pa) || (ack_b && pb)) begin
          errors++;
          $display("FAIL ack_pulse: ack high %0d cycles, required 1", 2);
        end
        if (name_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: data %08h with no transaction queued", act);
        end else begin
          n = name_q.pop_front();
          e = exp_q.pop_front();
          c = chk_q.pop_front();
          if (c) begin
            checks++;
            if (act !== e) begin
              errors++;
              $display("FAIL %s: got %08h required %08h", n, act, e);
            end
          end
        end
      end
      pa = ack_a;
      pb = ack_b;
    end
  endtask

  task automatic wb_drive(input bit inst_b, input bit ctl, input bit wr, input int a,
                          input logic [31:0] d, input bit chk, input logic [31:0] e,
                          input string n);
    name_q.push_back(n);
    exp_q.push_back(e);
    chk_q.push_back(chk);
    adr  = 11'(a);
    wdat = d;
    we   = wr;
    stb  = 1'b1;
    if (inst_b) begin
      cyc_ctl_b = ctl;
      cyc_buf_b = !ctl;
    end else begin
      cyc_ctl_a = ctl;
      cyc_buf_a = !ctl;
    end
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(ack_a || ack_b) && n < 8);
    if (!(ack_a || ack_b)) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: no ack after %0d cycles, required 1", n);
      if (name_q.size() > 0) begin
        void'(name_q.pop_back());
        void'(exp_q.pop_back());
        void'(chk_q.pop_back());
      end
    end
    cyc_buf_a = 1'b0; cyc_ctl_a = 1'b0;
    cyc_buf_b = 1'b0; cyc_ctl_b = 1'b0;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb(input bit inst_b, input bit ctl, input bit wr, input int a,
                    input logic [31:0] d, input bit chk, input logic [31:0] e, input string n);
    @(posedge clk); #1;
    wb_drive(inst_b, ctl, wr, a, d, chk, e, n);
    wait_ack();
  endtask

  task automatic ctl_wr(input bit b, input logic [31:0] d);
    wb(b, 1'b1, 1'b1, 0, d, 1'b0, 32'd0, "ctl_wr");
  endtask

  task automatic ctl_rd(input bit b, input int a, input logic [31:0] e, input string n);
    wb(b, 1'b1, 1'b0, a, 32'd0, 1'b1, e, n);
  endtask

  task automatic buf_rd(input bit b, input int a, input logic [31:0] e, input string n);
    wb(b, 1'b0, 1'b0, a, 32'd0, 1'b1, e, n);
  endtask

  // PCLK low for two clocks with the byte presented, then rising
  task automatic cam_byte(input logic [7:0] b);
    @(posedge clk); #1;
    pclk = 1'b0;
    cam  = b;
    @(posedge clk);
    @(posedge clk); #1;
    pclk = 1'b1;
  endtask

  task automatic frame_start();
    @(posedge clk); #1;
    vsync = 1'b1;
    repeat (4) @(posedge clk);
    #1 href = 1'b1;
  endtask

  task automatic frame_end();
    repeat (4) @(posedge clk);
    #1 href = 1'b0;
    pclk = 1'b0;
    repeat (2) @(posedge clk);
    #1 vsync = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack_a", 32'(ack_a), 32'd0);
    check("rst_dat_a", dat_a, 32'd0);
    check("rst_rdy_a", 32'(rdy_a), 32'd0);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    ctl_rd(1'b0, 0, 32'h0000_0000, "a_status_after_reset");
    ctl_rd(1'b1, 0, 32'h0000_0000, "b_status_after_reset");

    // Eight-byte frame into bank 0
    ctl_wr(1'b0, 32'h1);
    repeat (4) @(posedge clk);
    frame_start();
    for (int i = 1; i <= 8; i++) cam_byte(8'(i));
    frame_end();
    ctl_rd(1'b0, 1, 32'd2, "a_fill_8bytes");
    ctl_rd(1'b0, 0, 32'h0000_0115, "a_status_frame1");
    check("a_bank_rdy", 32'(rdy_a), 32'd1);
    buf_rd(1'b0, 0, 32'h0102_0304, "a_bank0_word0");
    buf_rd(1'b0, 1, 32'h0506_0708, "a_bank0_word1");
    wb(1'b0, 1'b0, 1'b1, 0, 32'hDEAD_BEEF, 1'b0, 32'd0, "buf_wr");
    buf_rd(1'b0, 0, 32'h0102_0304, "a_buf_write_ignored");

    // Six-byte frame: partial last word zero padded
    frame_start();
    for (int i = 0; i < 6; i++) cam_byte(8'(8'hAA + i));
    frame_end();
    ctl_rd(1'b0, 1, 32'd2, "a_fill_6bytes");
    buf_rd(1'b0, 512, 32'hAAAB_ACAD, "a_bank1_word0");
    buf_rd(1'b0, 513, 32'hAEAF_0000, "a_bank1_word1_padded");
    ctl_rd(1'b0, 0, 32'h0000_0325, "a_status_frame2");

    // Disable after two bytes, then a fresh frame must start clean at word 0
    frame_start();
    cam_byte(8'h11);
    cam_byte(8'h22);
    repeat (4) @(posedge clk);
    ctl_wr(1'b0, 32'h0);
    ctl_rd(1'b0, 0, 32'h0000_0320, "a_status_disabled");
    frame_end();
    ctl_wr(1'b0, 32'h1);
    repeat (4) @(posedge clk);
    frame_start();
    for (int i = 0; i < 4; i++) cam_byte(8'(8'h31 + i));
    frame_end();
    ctl_rd(1'b0, 1, 32'd1, "a_fill_after_reenable");
    buf_rd(1'b0, 1024, 32'h3132_3334, "a_bank2_word0_clean");
    ctl_rd(1'b0, 0, 32'h0000_0735, "a_status_frame3");
    ctl_wr(1'b0, 32'h0);

    // Small instance: 40 bytes overrun both banks and stall
    ctl_wr(1'b1, 32'h1);
    repeat (4) @(posedge clk);
    frame_start();
    for (int i = 0; i < 40; i++) cam_byte(8'(i));
    frame_end();
    ctl_rd(1'b1, 0, 32'h0000_030F, "b_status_stall_overflow");
    ctl_rd(1'b1, 1, 32'd4, "b_fill_full_bank");
    buf_rd(1'b1, 3, 32'h0C0D_0E0F, "b_bank0_word3");
    buf_rd(1'b1, 4, 32'h1011_1213, "b_bank1_word0");
    check("b_bank_rdy", 32'(rdy_b), 32'd1);
    ctl_wr(1'b1, 32'h101);
    ctl_rd(1'b1, 0, 32'h0000_0207, "b_status_release0_arm");
    ctl_wr(1'b1, 32'h2);
    ctl_rd(1'b1, 0, 32'h0000_0200, "b_status_overflow_cleared");
    ctl_wr(1'b1, 32'h201);
    ctl_rd(1'b1, 0, 32'h0000_0005, "b_status_all_released");

    // Release of bank 1 lands on the cycle bank 1 closes
    repeat (4) @(posedge clk);
    frame_start();
    for (int i = 0; i < 31; i++) cam_byte(8'(8'h40 + i));
    cam_byte(8'h5F);
    @(posedge clk);
    @(posedge clk); #1;
    wb_drive(1'b1, 1'b1, 1'b1, 0, 32'h201, 1'b0, 32'd0, "ctl_wr_release_on_close");
    wait_ack();
    frame_end();
    ctl_rd(1'b1, 0, 32'h0000_030D, "b_status_set_beats_release");
    buf_rd(1'b1, 0, 32'h4041_4243, "b_bank0_word0_frame2");
    buf_rd(1'b1, 7, 32'h5C5D_5E5F, "b_bank1_word3_frame2");

    // Reset asserted in the middle of a frame
    frame_start();
    cam_byte(8'h77);
    cam_byte(8'h88);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ack_a", 32'(ack_a), 32'd0);
    check("midrst_dat_a", dat_a, 32'd0);
    check("midrst_rdy_a", 32'(rdy_a), 32'd0);
    check("midrst_dat_b", dat_b, 32'd0);
    check("midrst_rdy_b", 32'(rdy_b), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    frame_end();
    ctl_rd(1'b0, 0, 32'h0000_0000, "a_status_after_midrst");
    ctl_rd(1'b0, 1, 32'd0, "a_fill_after_midrst");
    ctl_rd(1'b1, 0, 32'h0000_0000, "b_status_after_midrst");
    ctl_rd(1'b1, 1, 32'd0, "b_fill_after_midrst");
    check("a_rdy_after_midrst", 32'(rdy_a), 32'd0);

    repeat (4) @(posedge clk);
    checks++;
    if (name_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", name_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
